serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Serial transmitter that sits directly upstream of the serial receive/memory-write stage. Accepts one 10-bit address plus 8-bit data word per handshake and shifts it out on a single line as one asynchronous-style frame: start bit, 18 payload bits LSB first, stop bit(s). The bit period matches the receiver's sampling: 8 clocks per bit, with the receiver sampling at mid-bit.

## Interface
- BIT_CLKS, 8, clocks per serial bit; must equal the receiver's bit period.
- STOP_BITS, 1, number of stop bits (line high) appended to each frame; range 1..4.
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- soc  in  1  start-of-conversion request; sampled only while eoc=1.
- a9_a0  in  10  address field; captured on the accept edge.
- d7_d0  in  8  data field; captured on the accept edge.
- eoc  out  1  1 = idle and ready to accept; 0 = frame in progress.
- txd  out  1  serial line; idles high (marking).

## Operation
- Reset, applied on any edge with reset=1: txd=1, eoc=1, state=IDLE; shift register and counters cleared. Reset mid-frame aborts immediately; txd is 1 from the next cycle. The truncated frame is not retried.
- States: IDLE, START, DATA, STOP.
- IDLE: txd=1, eoc=1. On an edge with soc=1, perform all of the following: SHIFT <= {d7_d0, a9_a0}; txd <= 0; eoc <= 0; timer <= BIT_CLKS-1; go to START.
- START: hold txd=0 for BIT_CLKS cycles. Then txd <= SHIFT[0], bit count <= 18, and go to DATA.
- DATA: each bit is held BIT_CLKS cycles. At each bit boundary, SHIFT shifts right by one and txd <= the new SHIFT[0].
  - Transmit order is a0..a9, then d0..d7. This matches a receiver that shifts in at the MSB and shifts right.
  - After the 18th bit, txd <= 1 and go to STOP.
- STOP: txd=1 for STOP_BITS*BIT_CLKS cycles, then eoc <= 1 and go to IDLE.
- soc while eoc=0 is ignored, not queued. a9_a0 and d7_d0 may change freely after the accept edge.
- soc held high continuously produces back-to-back frames. eoc is high for exactly one cycle between frames, and txd stays 1 during that cycle.
- Counters:
  - Bit-period timer: clog2(BIT_CLKS) bits, counts down, terminal count at 0.
  - Bit counter: 5 bits, counts down 18→1.
  - No wrap-around is reachable in either counter.

## Timing
- Let edge k be the accept edge (IDLE, soc=1). Cycle n means the cycle after edge n.
- txd=0 in cycles k..k+BIT_CLKS-1.
- Payload bit i (i=0..17) on txd in cycles k+BIT_CLKS*(i+1) .. k+BIT_CLKS*(i+2)-1.
- Stop bit(s) occupy cycles k+19*BIT_CLKS .. k+(19+STOP_BITS)*BIT_CLKS-1.
- eoc=1 from cycle k+(19+STOP_BITS)*BIT_CLKS. With defaults, that is k+160.
- Accept-to-next-accept minimum with defaults: 161 clocks. The receiver needs 2 clocks after its stop sample (4 clocks into the stop bit), so 1 stop bit is sufficient.
- txd and eoc are registered outputs with no combinational path from inputs.

## Structure
- Shared package holds:
  - ADDR_W=10, DATA_W=8, FRAME_BITS=18, default BIT_CLKS=8.
  - START_BIT=1'b0, STOP_BIT=1'b1.
  - State encoding: IDLE=0, START=1, DATA=2, STOP=3.
  - The receiver references the same constants.
- One sub-module: tx_bit_timer. It is a loadable down-counter that outputs a one-cycle tick at terminal count, and is reused by the receiver's wait logic.
- Top level: FSM, 18-bit shift register, 5-bit bit counter, registered txd/eoc.

## Test plan
- Reset, then idle 20 cycles -> txd=1, eoc=1 throughout; soc=0 causes no activity.
- a9_a0=10'h2A5, d7_d0=8'hC3, soc pulsed 1 cycle at edge k -> eoc=0 at k; txd low for 8 cycles; bits sampled mid-bit read 1,0,1,0,0,1,0,1,0,1 then 1,1,0,0,0,0,1,1; stop=1; eoc=1 at cycle k+160.
- Loopback into the receiver stage with random address/data, 50 frames, soc held high -> each mw_ pulse presents a matching address/data pair; eoc high exactly 1 cycle between frames.
- soc asserted and inputs changed at k+40 mid-frame -> frame unchanged; no second frame starts until eoc=1.
- reset asserted at k+75 (inside DATA) -> txd=1 and eoc=1 from the next cycle; a new soc 3 cycles later produces a clean full frame.
- BIT_CLKS=16, STOP_BITS=2 -> each bit lasts 16 cycles; stop lasts 32 cycles; eoc rises at k+336.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
// Shared constants, state encoding and helpers for the serial frame link.
// The receiver stage imports the same package so both ends agree on the framing.
package serial_frame_tx_pkg;

  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 8;
  localparam int FRAME_BITS   = ADDR_W + DATA_W;
  localparam int BIT_CLKS_DEF = 8;
  localparam int BCNT_W       = 5;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Bit-period timer width; a one-clock bit period still needs a 1-bit counter.
  function automatic int timer_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/response bundle between the frame source and the transmitter.
interface serial_frame_tx_if;
  import serial_frame_tx_pkg::*;

  logic              soc;
  logic [ADDR_W-1:0] a9_a0;
  logic [DATA_W-1:0] d7_d0;
  logic              eoc;
  logic              txd;

  modport master (output soc, output a9_a0, output d7_d0, input eoc, input txd);
  modport slave  (input soc, input a9_a0, input d7_d0, output eoc, output txd);

endinterface

// File: rtl/tx_bit_timer.sv
// Loadable down-counter; tick is high for the single cycle the count sits at zero
// while enabled. Also used by the receiver's wait logic.
module tx_bit_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: a load wins, otherwise decrement and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 18 payload bits (address then data,
// LSB first), STOP_BITS stop bits. txd and eoc come straight from flops.
//
// state | meaning
// IDLE  | line marking, eoc=1, waiting for soc
// START | start bit on the line
// DATA  | payload bits shifting out, bit counter 18..1
// STOP  | stop bit(s) on the line, bit counter STOP_BITS..1
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int BIT_CLKS  = BIT_CLKS_DEF,
  parameter int STOP_BITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  serial_frame_tx_if.slave  bus
);

  localparam int                TW        = timer_width(BIT_CLKS);
  localparam logic [TW-1:0]     RELOAD    = TW'(BIT_CLKS - 1);
  localparam logic [BCNT_W-1:0] BITS_INIT = BCNT_W'(FRAME_BITS);
  localparam logic [BCNT_W-1:0] STOP_INIT = BCNT_W'(STOP_BITS);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(1);

  tx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic                  txd_q, txd_d;
  logic                  eoc_q, eoc_d;
  logic                  tmr_load;
  logic                  tmr_en;
  logic                  tmr_tick;

  assign tmr_en = (state_q != IDLE);

  tx_bit_timer #(.WIDTH(TW)) u_bit_timer (
    .clock      (clock),
    .reset      (reset),
    .en_i       (tmr_en),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .tick_o     (tmr_tick)
  );

  // Next-state and next-output decode; every bit boundary reloads the timer.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
    txd_d    = txd_q;
    eoc_d    = eoc_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = STOP_BIT;
        eoc_d = 1'b1;
        if (bus.soc) begin
          shift_d  = {bus.d7_d0, bus.a9_a0};
          txd_d    = START_BIT;
          eoc_d    = 1'b0;
          tmr_load = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tmr_tick) begin
          txd_d    = shift_q[0];
          bcnt_d   = BITS_INIT;
          tmr_load = 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (tmr_tick) begin
          tmr_load = 1'b1;
          if (bcnt_q == BCNT_LAST) begin
            txd_d   = STOP_BIT;
            bcnt_d  = STOP_INIT;
            state_d = STOP;
          end else begin
            // shift_q[1] is the bit that lands in position 0 after this shift.
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bcnt_d  = bcnt_q - BCNT_LAST;
          end
        end
      end
      STOP: begin
        if (tmr_tick) begin
          if (bcnt_q == BCNT_LAST) begin
            eoc_d   = 1'b1;
            state_d = IDLE;
          end else begin
            bcnt_d   = bcnt_q - BCNT_LAST;
            tmr_load = 1'b1;
          end
        end
      end
      default: begin
        txd_d   = STOP_BIT;
        eoc_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, shift register, bit counter and output flops; reset aborts any frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      txd_q   <= STOP_BIT;
      eoc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      txd_q   <= txd_d;
      eoc_q   <= eoc_d;
    end
  end

  assign bus.txd = txd_q;
  assign bus.eoc = eoc_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (8 clk/1 stop and 16 clk/2 stop) share
// stimulus; a per-cycle queue of expected line levels serves as the reference.
module tb_serial_frame_tx;

  localparam int BCA = 8;
  localparam int SBA = 1;
  localparam int BCB = 16;
  localparam int SBB = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       soc   = 1'b0;
  logic [9:0] addr  = '0;
  logic [7:0] data  = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic qa[$];
  logic qb[$];

  serial_frame_tx_if if_a();
  serial_frame_tx_if if_b();

  assign if_a.soc   = soc;
  assign if_a.a9_a0 = addr;
  assign if_a.d7_d0 = data;
  assign if_b.soc   = soc;
  assign if_b.a9_a0 = addr;
  assign if_b.d7_d0 = data;

  serial_frame_tx #(.BIT_CLKS(BCA), .STOP_BITS(SBA)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a)
  );

  serial_frame_tx #(.BIT_CLKS(BCB), .STOP_BITS(SBB)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line level of frame slot j: 0 start, 1..18 payload a0..a9 d0..d7, then stop.
  function automatic logic frame_bit(input int j, input logic [9:0] a, input logic [7:0] d);
    logic [17:0] p;
    p = {d, a};
    if (j == 0) return 1'b0;
    if (j <= 18) return p[j-1];
    return 1'b1;
  endfunction

  // Reference: on an accept, queue the whole frame's per-cycle line levels.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() == 0) begin
        if (soc) for (int j = 0; j < (19 + SBA) * BCA; j++) qa.push_back(frame_bit(j / BCA, addr, data));
      end else begin
        void'(qa.pop_front());
      end
      if (qb.size() == 0) begin
        if (soc) for (int j = 0; j < (19 + SBB) * BCB; j++) qb.push_back(frame_bit(j / BCB, addr, data));
      end else begin
        void'(qb.pop_front());
      end
    end
  end

  // Every cycle: both outputs of both instances against the reference.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("a_txd", if_a.txd, (qa.size() == 0) ? 1'b1 : qa[0]);
      chk("a_eoc", if_a.eoc, qa.size() == 0);
      chk("b_txd", if_b.txd, (qb.size() == 0) ? 1'b1 : qb[0]);
      chk("b_eoc", if_b.eoc, qb.size() == 0);
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wait_both_idle(input int lim);
    int n;
    n = 0;
    while (!(if_a.eoc && if_b.eoc) && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk("idle_wait", {if_a.eoc, if_b.eoc}, 2'b11);
  endtask

  task automatic pulse_soc(output int k);
    soc = 1'b1;
    @(negedge clock);
    k = cyc;
    soc = 1'b0;
    addr = 10'($urandom);
    data = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int expv[18];
    expv = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1};

    repeat (2) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(negedge clock);

    // Directed frame 2A5/C3.
    addr = 10'h2A5;
    data = 8'hC3;
    pulse_soc(k);
    chk("a_eoc_at_accept", if_a.eoc, 1'b0);
    chk("a_start_bit", if_a.txd, 1'b0);
    for (int i = 0; i < 18; i++) begin
      wait_cyc(k + BCA * (i + 1) + BCA / 2);
      chk($sformatf("a_mid_bit%0d", i), if_a.txd, expv[i]);
    end
    wait_cyc(k + BCA * 19 + BCA / 2);
    chk("a_stop_bit", if_a.txd, 1'b1);
    wait_cyc(k + 159);
    chk("a_eoc_k159", if_a.eoc, 1'b0);
    wait_cyc(k + 160);
    chk("a_eoc_k160", if_a.eoc, 1'b1);
    wait_cyc(k + 335);
    chk("b_eoc_k335", if_b.eoc, 1'b0);
    wait_cyc(k + 336);
    chk("b_eoc_k336", if_b.eoc, 1'b1);
    wait_both_idle(1000);

    // soc and new inputs mid-frame: ignored until the frame completes.
    addr = 10'($urandom);
    data = 8'($urandom);
    pulse_soc(k);
    wait_cyc(k + 39);
    soc  = 1'b1;
    addr = 10'($urandom);
    data = 8'($urandom);
    wait_cyc(k + 100);
    chk("a_eoc_midframe", if_a.eoc, 1'b0);
    wait_cyc(k + 162);
    soc = 1'b0;
    wait_both_idle(1000);

    // Reset inside DATA, then a fresh frame three cycles later.
    addr = 10'($urandom);
    data = 8'($urandom);
    pulse_soc(k);
    wait_cyc(k + 74);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("a_txd_after_reset", if_a.txd, 1'b1);
    chk("a_eoc_after_reset", if_a.eoc, 1'b1);
    repeat (2) @(negedge clock);
    addr = 10'($urandom);
    data = 8'($urandom);
    pulse_soc(k);
    wait_both_idle(1000);

    // Back-to-back frames with soc held high and fresh random data per frame.
    soc = 1'b1;
    for (int f = 0; f < 50; f++) begin
      int n;
      n = 0;
      while (!if_a.eoc && n < 400) begin
        @(negedge clock);
        n++;
      end
      chk("b2b_accept_wait", if_a.eoc, 1'b1);
      addr = 10'($urandom);
      data = 8'($urandom);
      @(negedge clock);
    end
    soc = 1'b0;
    wait_both_idle(1000);
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
